pong_match_ctrl: RTL and testbench

PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

---
 rtl/pong_pkg.sv | 31 +++
 rtl/pong_match_ctrl_if.sv | 27 ++
 rtl/pong_frame_tick.sv | 41 ++++
 rtl/pong_match_ctrl.sv | 133 +++++++++++++
 tb/tb_pong_match_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// Shared Pong definitions: FSM state codes, default game constants and BCD helper.
// Used by the match controller and the physics block.
package pong_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_MISS  = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  localparam int unsigned DEF_SERVE_FRAMES   = 60;
  localparam int unsigned DEF_MISS_FRAMES    = 30;
  localparam int unsigned DEF_LIVES          = 3;
  localparam int unsigned DEF_HITS_PER_LEVEL = 5;
  localparam int unsigned DEF_MAX_LEVEL      = 3;

  // Two-digit BCD increment, saturating at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v[3:0] == 4'd9) begin
      if (v[7:4] != 4'd9) begin
        r = {v[7:4] + 4'd1, 4'd0};
      end
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/pong_match_ctrl_if.sv
// Controller <-> physics link: event pulses from physics, run/recentre/speed back to it.
// master = match controller, slave = physics block.
interface pong_match_ctrl_if;

  logic       hit;
  logic       miss;
  logic       physics_run;
  logic       ball_reset;
  logic [1:0] speed_level;

  modport master (
    input  hit,
    input  miss,
    output physics_run,
    output ball_reset,
    output speed_level
  );

  modport slave (
    output hit,
    output miss,
    input  physics_run,
    input  ball_reset,
    input  speed_level
  );

endinterface

// File: rtl/pong_frame_tick.sv
// Frame tick from the vsync rising edge, and a once-per-frame debounced button press.
// btn_press is aligned with frame_tick.
module pong_frame_tick (
  input  logic pixel_clk,
  input  logic rst,
  input  logic v_sync_pulse,
  input  logic n_btn,
  output logic frame_tick,
  output logic btn_press
);

  logic vsync_d;
  logic pressed_s1;
  logic pressed_s2;
  logic pressed_prev;
  logic vsync_rise;

  assign vsync_rise = v_sync_pulse & ~vsync_d;

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      vsync_d      <= 1'b0;
      pressed_s1   <= 1'b0;
      pressed_s2   <= 1'b0;
      pressed_prev <= 1'b0;
      frame_tick   <= 1'b0;
      btn_press    <= 1'b0;
    end else begin
      vsync_d    <= v_sync_pulse;
      // Button is asynchronous to the pixel clock; resynchronise before use.
      pressed_s1 <= ~n_btn;
      pressed_s2 <= pressed_s1;
      frame_tick <= vsync_rise;
      btn_press  <= vsync_rise & pressed_s2 & ~pressed_prev;
      if (vsync_rise) begin
        pressed_prev <= pressed_s2;
      end
    end
  end

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match controller: serve/play/miss/over sequencing, lives, BCD score and speed level.
// All outputs are registered from the next-state logic.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned SERVE_FRAMES   = DEF_SERVE_FRAMES,
  parameter int unsigned MISS_FRAMES    = DEF_MISS_FRAMES,
  parameter int unsigned LIVES          = DEF_LIVES,
  parameter int unsigned HITS_PER_LEVEL = DEF_HITS_PER_LEVEL,
  parameter int unsigned MAX_LEVEL      = DEF_MAX_LEVEL
) (
  input  logic                     pixel_clk,
  input  logic                     rst,
  input  logic                     v_sync_pulse,
  input  logic                     n_btn,
  pong_match_ctrl_if.master        phys,
  output logic                     frame_tick,
  output logic [7:0]               score_bcd,
  output logic [2:0]               lives_left,
  output logic [2:0]               state,
  output logic                     game_over
);

  localparam int unsigned CNT_MAX = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
  localparam int unsigned CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam int unsigned HW      = (HITS_PER_LEVEL < 2) ? 1 : $clog2(HITS_PER_LEVEL + 1);

  logic          btn_press;
  logic [CW-1:0] frame_cnt;
  logic [HW-1:0] hit_cnt;

  logic [2:0]    state_nxt;
  logic [CW-1:0] frame_cnt_nxt;
  logic [HW-1:0] hit_cnt_nxt;
  logic [7:0]    score_nxt;
  logic [2:0]    lives_nxt;
  logic [1:0]    speed_nxt;

  pong_frame_tick u_frame_tick (
    .pixel_clk    (pixel_clk),
    .rst          (rst),
    .v_sync_pulse (v_sync_pulse),
    .n_btn        (n_btn),
    .frame_tick   (frame_tick),
    .btn_press    (btn_press)
  );

  always_comb begin
    state_nxt     = state;
    frame_cnt_nxt = frame_cnt;
    hit_cnt_nxt   = hit_cnt;
    score_nxt     = score_bcd;
    lives_nxt     = lives_left;
    speed_nxt     = phys.speed_level;

    case (state)
      ST_IDLE: begin
        if (btn_press) begin
          state_nxt   = ST_SERVE;
          score_nxt   = '0;
          lives_nxt   = 3'(LIVES);
          speed_nxt   = '0;
          hit_cnt_nxt = '0;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          if (frame_cnt <= CW'(1)) state_nxt = ST_PLAY;
          else                     frame_cnt_nxt = frame_cnt - CW'(1);
        end
      end
      ST_PLAY: begin
        // A miss wins over a simultaneous hit; the hit is dropped.
        if (phys.miss) begin
          lives_nxt = (lives_left == 3'd0) ? 3'd0 : lives_left - 3'd1;
          if (lives_left <= 3'd1) begin
            state_nxt = ST_OVER;
          end else begin
            state_nxt     = ST_MISS;
            frame_cnt_nxt = CW'(MISS_FRAMES);
          end
        end else if (phys.hit) begin
          score_nxt = bcd_inc(score_bcd);
          if (hit_cnt >= HW'(HITS_PER_LEVEL - 1)) begin
            hit_cnt_nxt = '0;
            if (phys.speed_level < 2'(MAX_LEVEL)) speed_nxt = phys.speed_level + 2'd1;
          end else begin
            hit_cnt_nxt = hit_cnt + HW'(1);
          end
        end
      end
      ST_MISS: begin
        if (frame_tick) begin
          if (frame_cnt <= CW'(1)) state_nxt = ST_SERVE;
          else                     frame_cnt_nxt = frame_cnt - CW'(1);
        end
      end
      ST_OVER: begin
        if (btn_press) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (state_nxt == ST_SERVE && state != ST_SERVE) begin
      frame_cnt_nxt = CW'(SERVE_FRAMES);
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      frame_cnt        <= '0;
      hit_cnt          <= '0;
      score_bcd        <= '0;
      lives_left       <= 3'(LIVES);
      phys.speed_level <= '0;
      phys.physics_run <= 1'b0;
      phys.ball_reset  <= 1'b0;
      game_over        <= 1'b0;
    end else begin
      state            <= state_nxt;
      frame_cnt        <= frame_cnt_nxt;
      hit_cnt          <= hit_cnt_nxt;
      score_bcd        <= score_nxt;
      lives_left       <= lives_nxt;
      phys.speed_level <= speed_nxt;
      phys.physics_run <= (state_nxt == ST_PLAY);
      phys.ball_reset  <= (state_nxt == ST_SERVE) && (state != ST_SERVE);
      game_over        <= (state_nxt == ST_OVER);
    end
  end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with short serve/miss holds, two lives and two hits per level.
module tb_pong_match_ctrl;
  import pong_pkg::*;

  logic       pixel_clk = 1'b0;
  logic       rst;
  logic       v_sync_pulse;
  logic       n_btn;
  logic       frame_tick;
  logic [7:0] score_bcd;
  logic [2:0] lives_left;
  logic [2:0] state;
  logic       game_over;

  int n_tests = 0;
  int n_fail  = 0;
  int n_br    = 0;
  int n_serve = 0;
  int n_ft    = 0;
  logic [2:0] prev_st = ST_IDLE;

  pong_match_ctrl_if phys_if ();

  pong_match_ctrl #(
    .SERVE_FRAMES   (2),
    .MISS_FRAMES    (2),
    .LIVES          (2),
    .HITS_PER_LEVEL (2),
    .MAX_LEVEL      (3)
  ) dut (
    .pixel_clk    (pixel_clk),
    .rst          (rst),
    .v_sync_pulse (v_sync_pulse),
    .n_btn        (n_btn),
    .phys         (phys_if.master),
    .frame_tick   (frame_tick),
    .score_bcd    (score_bcd),
    .lives_left   (lives_left),
    .state        (state),
    .game_over    (game_over)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic tick();
    @(posedge pixel_clk);
    #1;
    if (phys_if.ball_reset) n_br++;
    if (frame_tick) n_ft++;
    if (state == ST_SERVE && prev_st != ST_SERVE) n_serve++;
    prev_st = state;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic frame();
    v_sync_pulse = 1'b1;
    repeat (3) tick();
    v_sync_pulse = 1'b0;
    repeat (3) tick();
  endtask

  task automatic hit_pulse();
    phys_if.hit = 1'b1;
    tick();
    phys_if.hit = 1'b0;
    tick();
  endtask

  task automatic set_btn(input logic pressed);
    n_btn = ~pressed;
    repeat (3) tick();
  endtask

  initial begin
    rst          = 1'b1;
    v_sync_pulse = 1'b0;
    n_btn        = 1'b1;
    phys_if.hit  = 1'b0;
    phys_if.miss = 1'b0;
    repeat (3) tick();

    check("rst_state",  {5'd0, state}, 8'd0);
    check("rst_lives",  {5'd0, lives_left}, 8'd2);
    check("rst_score",  score_bcd, 8'h00);
    check("rst_speed",  {6'd0, phys_if.speed_level}, 8'd0);
    check("rst_run",    {7'd0, phys_if.physics_run}, 8'd0);
    check("rst_breset", {7'd0, phys_if.ball_reset}, 8'd0);
    check("rst_over",   {7'd0, game_over}, 8'd0);
    check("rst_ftick",  {7'd0, frame_tick}, 8'd0);
    rst = 1'b0;
    repeat (2) tick();

    // vsync held high for 10 cycles yields a single tick one cycle after the rise
    n_ft = 0;
    v_sync_pulse = 1'b1;
    check("ft_before_edge", {7'd0, frame_tick}, 8'd0);
    tick();
    check("ft_after_edge", {7'd0, frame_tick}, 8'd1);
    repeat (9) tick();
    check("ft_count", 8'(n_ft), 8'd1);
    check("idle_no_press", {5'd0, state}, {5'd0, ST_IDLE});
    v_sync_pulse = 1'b0;
    repeat (3) tick();

    // button held through 5 frames: one serve, then play after two ticks
    n_br = 0;
    n_serve = 0;
    set_btn(1'b1);
    frame();
    check("serve_entry", {5'd0, state}, {5'd0, ST_SERVE});
    check("serve_breset_cnt", 8'(n_br), 8'd1);
    frame();
    check("serve_hold", {5'd0, state}, {5'd0, ST_SERVE});
    check("serve_run_off", {7'd0, phys_if.physics_run}, 8'd0);
    frame();
    check("play_entry", {5'd0, state}, {5'd0, ST_PLAY});
    check("play_run_on", {7'd0, phys_if.physics_run}, 8'd1);
    frame();
    frame();
    check("play_held", {5'd0, state}, {5'd0, ST_PLAY});
    check("single_serve", 8'(n_serve), 8'd1);
    check("single_breset", 8'(n_br), 8'd1);
    set_btn(1'b0);

    // hits: BCD carry at 10, speed saturates at 3
    repeat (2) hit_pulse();
    check("score_2", score_bcd, 8'h02);
    check("speed_1", {6'd0, phys_if.speed_level}, 8'd1);
    repeat (8) hit_pulse();
    check("score_10", score_bcd, 8'h10);
    check("speed_sat_10", {6'd0, phys_if.speed_level}, 8'd3);
    repeat (2) hit_pulse();
    check("score_12", score_bcd, 8'h12);
    check("speed_sat_12", {6'd0, phys_if.speed_level}, 8'd3);
    check("play_after_hits", {5'd0, state}, {5'd0, ST_PLAY});

    // simultaneous hit and miss: miss wins
    phys_if.hit  = 1'b1;
    phys_if.miss = 1'b1;
    tick();
    phys_if.hit  = 1'b0;
    phys_if.miss = 1'b0;
    check("hm_lives", {5'd0, lives_left}, 8'd1);
    check("hm_score", score_bcd, 8'h12);
    check("hm_state", {5'd0, state}, {5'd0, ST_MISS});
    check("hm_run_off", {7'd0, phys_if.physics_run}, 8'd0);
    n_br = 0;
    frame();
    check("miss_hold", {5'd0, state}, {5'd0, ST_MISS});
    frame();
    check("miss_to_serve", {5'd0, state}, {5'd0, ST_SERVE});
    check("miss_breset", 8'(n_br), 8'd1);
    frame();
    frame();
    check("replay", {5'd0, state}, {5'd0, ST_PLAY});

    // last life lost -> OVER; hits ignored
    phys_if.miss = 1'b1;
    tick();
    phys_if.miss = 1'b0;
    check("over_state", {5'd0, state}, {5'd0, ST_OVER});
    check("over_flag", {7'd0, game_over}, 8'd1);
    check("over_lives", {5'd0, lives_left}, 8'd0);
    repeat (2) hit_pulse();
    check("over_score_held", score_bcd, 8'h12);
    check("over_speed_held", {6'd0, phys_if.speed_level}, 8'd3);
    check("over_stays", {5'd0, state}, {5'd0, ST_OVER});

    // press -> IDLE, release, press -> SERVE with fresh match values
    set_btn(1'b1);
    frame();
    check("over_to_idle", {5'd0, state}, {5'd0, ST_IDLE});
    check("idle_flag_clr", {7'd0, game_over}, 8'd0);
    set_btn(1'b0);
    frame();
    check("idle_no_repress", {5'd0, state}, {5'd0, ST_IDLE});
    set_btn(1'b1);
    n_br = 0;
    frame();
    check("new_serve", {5'd0, state}, {5'd0, ST_SERVE});
    check("new_score", score_bcd, 8'h00);
    check("new_lives", {5'd0, lives_left}, 8'd2);
    check("new_speed", {6'd0, phys_if.speed_level}, 8'd0);
    check("new_breset", 8'(n_br), 8'd1);

    // reset mid-play with a simultaneous hit
    frame();
    frame();
    check("play_again", {5'd0, state}, {5'd0, ST_PLAY});
    repeat (7) hit_pulse();
    check("score_07", score_bcd, 8'h07);
    rst = 1'b1;
    phys_if.hit = 1'b1;
    tick();
    rst = 1'b0;
    phys_if.hit = 1'b0;
    check("midrst_state", {5'd0, state}, {5'd0, ST_IDLE});
    check("midrst_score", score_bcd, 8'h00);
    check("midrst_lives", {5'd0, lives_left}, 8'd2);
    check("midrst_run", {7'd0, phys_if.physics_run}, 8'd0);
    check("midrst_speed", {6'd0, phys_if.speed_level}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
